// File: rtl/decode_stage_param.sv
// Decode stage: splits the instruction word into register addresses, operands and an immediate; carries IC/PPCCB/PC along.
// Latency: 1 cycle from accept to oValid. Optional macro DECODE_BYPASS_EN forwards writeback data into the operands.
// Backpressure: valid/ready on both sides; a two-entry output+skid buffer; oReady is registered (!skid_full).
module decode_stage_param #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32,
    parameter int IC_W   = 32,
    parameter int NREGS  = 32
) (
    input  logic              Clk,
    input  logic              reset,
    input  logic              rf_we,
    input  logic [4:0]        WAddr,
    input  logic [DATA_W-1:0] WData,
    input  logic [IC_W-1:0]   iIC,
    input  logic              iPPCCB,
    input  logic [PC_W-1:0]   iPC,
    input  logic [31:0]       iIR,
    input  logic              iValid,
    output logic              oReady,
    input  logic              iR2Select,
    input  logic [1:0]        iSignExtCtrl,
    input  logic              flush,
    input  logic              iReady,
    output logic              oValid,
    output logic [IC_W-1:0]   oIC,
    output logic              oPPCCB,
    output logic [PC_W-1:0]   oPC,
    output logic [4:0]        oRDS,
    output logic [4:0]        oRS1,
    output logic [4:0]        oRS2,
    output logic [DATA_W-1:0] oOP1,
    output logic [DATA_W-1:0] oOP2,
    output logic [DATA_W-1:0] oIM
);

    localparam logic [1:0] EXT16 = 2'd0;
    localparam logic [1:0] EXT17 = 2'd1;
    localparam logic [1:0] EXT22 = 2'd2;
    localparam logic [1:0] EXT23 = 2'd3;

    typedef struct packed {
        logic [IC_W-1:0]   ic;
        logic              ppccb;
        logic [PC_W-1:0]   pc;
        logic [4:0]        rds;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [DATA_W-1:0] op1;
        logic [DATA_W-1:0] op2;
        logic [DATA_W-1:0] im;
    } beat_t;

    logic [DATA_W-1:0] rf_q [NREGS];
    beat_t out_q, out_d, skid_q, skid_d, dec_beat, out_ref, skid_ref;
    logic  out_vld_q, out_vld_d, skid_vld_q, skid_vld_d;
    logic  wr_en, accept, drain;

    // Opcode bits are not needed by this stage.
    logic unused_opc;
    assign unused_opc = ^iIR[31:27];

    // Writes to unimplemented addresses are ignored.
    assign wr_en  = rf_we && (int'(WAddr) < NREGS);
    assign accept = iValid && !skid_vld_q && !flush;
    assign drain  = out_vld_q && iReady;

    // Register file write port.
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
        end else if (rf_we) begin
            for (int i = 0; i < NREGS; i++)
                if (WAddr == 5'(i)) rf_q[i] <= WData;
        end
    end

    // Decode the incoming word; unimplemented registers read as zero.
    always_comb begin
        dec_beat       = '0;
        dec_beat.ic    = iIC;
        dec_beat.ppccb = iPPCCB;
        dec_beat.pc    = iPC;
        dec_beat.rds   = iIR[26:22];
        dec_beat.rs1   = iIR[21:17];
        dec_beat.rs2   = iR2Select ? iIR[26:22] : iIR[15:11];
        for (int i = 0; i < NREGS; i++) begin
            if (dec_beat.rs1 == 5'(i)) dec_beat.op1 = rf_q[i];
            if (dec_beat.rs2 == 5'(i)) dec_beat.op2 = rf_q[i];
        end
`ifdef DECODE_BYPASS_EN
        if (wr_en && dec_beat.rs1 == WAddr) dec_beat.op1 = WData;
        if (wr_en && dec_beat.rs2 == WAddr) dec_beat.op2 = WData;
`endif
        case (iSignExtCtrl)
            EXT16:   dec_beat.im = {{(DATA_W-16){iIR[15]}}, iIR[15:0]};
            EXT17:   dec_beat.im = {{(DATA_W-17){iIR[16]}}, iIR[16:0]};
            EXT22:   dec_beat.im = {{(DATA_W-22){iIR[21]}}, iIR[21:0]};
            EXT23:   dec_beat.im = {{(DATA_W-23){iIR[22]}}, iIR[22:0]};
            default: dec_beat.im = '0;
        endcase
    end

    // Held beats optionally track writeback so their operands stay current.
    always_comb begin
        out_ref  = out_q;
        skid_ref = skid_q;
`ifdef DECODE_BYPASS_EN
        if (wr_en && out_q.rs1 == WAddr)  out_ref.op1  = WData;
        if (wr_en && out_q.rs2 == WAddr)  out_ref.op2  = WData;
        if (wr_en && skid_q.rs1 == WAddr) skid_ref.op1 = WData;
        if (wr_en && skid_q.rs2 == WAddr) skid_ref.op2 = WData;
`endif
    end

    // Output/skid buffer control; skid is only ever full while output is full.
    always_comb begin
        out_d      = out_ref;
        skid_d     = skid_ref;
        out_vld_d  = out_vld_q;
        skid_vld_d = skid_vld_q;
        if (flush) begin
            out_vld_d  = 1'b0;
            skid_vld_d = 1'b0;
        end else if (!out_vld_q) begin
            if (accept) begin
                out_vld_d = 1'b1;
                out_d     = dec_beat;
            end
        end else if (!skid_vld_q) begin
            if (drain) begin
                if (accept) out_d = dec_beat;
                else        out_vld_d = 1'b0;
            end else if (accept) begin
                skid_vld_d = 1'b1;
                skid_d     = dec_beat;
            end
        end else if (drain) begin
            out_d      = skid_ref;
            skid_vld_d = 1'b0;
        end
    end

    // Buffer state registers.
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            out_q      <= '0;
            skid_q     <= '0;
            out_vld_q  <= 1'b0;
            skid_vld_q <= 1'b0;
        end else begin
            out_q      <= out_d;
            skid_q     <= skid_d;
            out_vld_q  <= out_vld_d;
            skid_vld_q <= skid_vld_d;
        end
    end

    assign oReady = !skid_vld_q;
    assign oValid = out_vld_q;
    assign oIC    = out_q.ic;
    assign oPPCCB = out_q.ppccb;
    assign oPC    = out_q.pc;
    assign oRDS   = out_q.rds;
    assign oRS1   = out_q.rs1;
    assign oRS2   = out_q.rs2;
    assign oOP1   = out_q.op1;
    assign oOP2   = out_q.op2;
    assign oIM    = out_q.im;

endmodule

// File: tb/tb_decode_stage_param.sv
// Directed bench for decode_stage_param built with NREGS=8 so the unimplemented-register case is reachable.
// Inputs change 1 time unit after the rising edge and outputs are sampled there too.
// Bypass expectations follow DECODE_BYPASS_EN as passed to the build.
module tb_decode_stage_param;

    localparam int DW = 32;

    logic          Clk = 1'b0;
    logic          reset;
    logic          rf_we;
    logic [4:0]    WAddr;
    logic [DW-1:0] WData;
    logic [31:0]   iIC;
    logic          iPPCCB;
    logic [31:0]   iPC;
    logic [31:0]   iIR;
    logic          iValid;
    logic          oReady;
    logic          iR2Select;
    logic [1:0]    iSignExtCtrl;
    logic          flush;
    logic          iReady;
    logic          oValid;
    logic [31:0]   oIC;
    logic          oPPCCB;
    logic [31:0]   oPC;
    logic [4:0]    oRDS, oRS1, oRS2;
    logic [DW-1:0] oOP1, oOP2, oIM;

    int total = 0;
    int bad   = 0;

    decode_stage_param #(.DATA_W(DW), .PC_W(32), .IC_W(32), .NREGS(8)) dut (
        .Clk(Clk), .reset(reset), .rf_we(rf_we), .WAddr(WAddr), .WData(WData),
        .iIC(iIC), .iPPCCB(iPPCCB), .iPC(iPC), .iIR(iIR), .iValid(iValid),
        .oReady(oReady), .iR2Select(iR2Select), .iSignExtCtrl(iSignExtCtrl),
        .flush(flush), .iReady(iReady), .oValid(oValid), .oIC(oIC),
        .oPPCCB(oPPCCB), .oPC(oPC), .oRDS(oRDS), .oRS1(oRS1), .oRS2(oRS2),
        .oOP1(oOP1), .oOP2(oOP2), .oIM(oIM)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [31:0] mk_ir(input logic [4:0] rds, input logic [4:0] rs1, input logic [4:0] rs2);
        return {5'b0, rds, rs1, 1'b0, rs2, 11'b0};
    endfunction

    logic [DW-1:0] exp_op1_byp, exp_op2_byp;

    initial begin
`ifdef DECODE_BYPASS_EN
        exp_op1_byp = 32'd5;
        exp_op2_byp = 32'd9;
`else
        exp_op1_byp = 32'd1;
        exp_op2_byp = 32'd2;
`endif
        reset = 1'b0; rf_we = 1'b0; WAddr = '0; WData = '0;
        iIC = '0; iPPCCB = 1'b0; iPC = '0; iIR = '0; iValid = 1'b0;
        iR2Select = 1'b0; iSignExtCtrl = 2'd0; flush = 1'b0; iReady = 1'b0;
        cyc(); cyc();
        chk("rst_ovalid", 64'(oValid), 64'd0);
        chk("rst_oready", 64'(oReady), 64'd1);
        chk("rst_oic",    64'(oIC),    64'd0);
        chk("rst_oop1",   64'(oOP1),   64'd0);
        chk("rst_oim",    64'(oIM),    64'd0);
        reset = 1'b1;
        cyc();

        // r1=1, r2=2
        rf_we = 1'b1; WAddr = 5'd1; WData = 32'd1; cyc();
        WAddr = 5'd2; WData = 32'd2; cyc();
        rf_we = 1'b0;

        // ADD r0,r1,r2
        iIR = mk_ir(5'd0, 5'd1, 5'd2); iIC = 32'd7; iPPCCB = 1'b1; iPC = 32'd8;
        iValid = 1'b1; iReady = 1'b1;
        cyc();
        iValid = 1'b0;
        chk("add_ovalid", 64'(oValid), 64'd1);
        chk("add_rds",    64'(oRDS),   64'd0);
        chk("add_rs1",    64'(oRS1),   64'd1);
        chk("add_op1",    64'(oOP1),   64'd1);
        chk("add_rs2",    64'(oRS2),   64'd2);
        chk("add_op2",    64'(oOP2),   64'd2);
        chk("add_ic",     64'(oIC),    64'd7);
        chk("add_ppccb",  64'(oPPCCB), 64'd1);
        chk("add_pc",     64'(oPC),    64'd8);
        cyc();
        chk("add_drained", 64'(oValid), 64'd0);

        // Immediate modes, streamed back to back
        iValid = 1'b1; iPPCCB = 1'b0;
        iIR = 32'h0000_8000; iSignExtCtrl = 2'd0; cyc();
        chk("imm_ext16", 64'(oIM), 64'hffff8000);
        iIR = 32'h0040_0000; iSignExtCtrl = 2'd3; cyc();
        chk("imm_ext23", 64'(oIM), 64'hffc00000);
        iIR = 32'h0020_0000; iSignExtCtrl = 2'd2; cyc();
        chk("imm_ext22", 64'(oIM), 64'hffe00000);
        iIR = 32'h0001_0000; iSignExtCtrl = 2'd1; cyc();
        chk("imm_ext17", 64'(oIM), 64'hffff0000);
        iIR = 32'h0000_7fff; iSignExtCtrl = 2'd0; cyc();
        chk("imm_ext16_pos", 64'(oIM), 64'h00007fff);
        iIR = mk_ir(5'd2, 5'd0, 5'd0); iR2Select = 1'b1; cyc();
        chk("st_rs2", 64'(oRS2), 64'd2);
        chk("st_op2", 64'(oOP2), 64'd2);
        iR2Select = 1'b0; iValid = 1'b0;
        cyc();
        chk("imm_drained", 64'(oValid), 64'd0);

        // Backpressure: three beats against iReady=0
        iReady = 1'b0; iIR = mk_ir(5'd3, 5'd1, 5'd2);
        iValid = 1'b1; iIC = 32'd1; cyc();
        chk("bp_out1",   64'(oIC),    64'd1);
        chk("bp_rdy1",   64'(oReady), 64'd1);
        iIC = 32'd2; cyc();
        chk("bp_rdy2",   64'(oReady), 64'd0);
        chk("bp_hold1",  64'(oIC),    64'd1);
        iIC = 32'd3; cyc();
        chk("bp_rdy3",   64'(oReady), 64'd0);
        chk("bp_hold1b", 64'(oIC),    64'd1);
        iReady = 1'b1; cyc();
        chk("bp_seq2",   64'(oIC),    64'd2);
        chk("bp_vld2",   64'(oValid), 64'd1);
        chk("bp_rdy4",   64'(oReady), 64'd1);
        cyc();
        iValid = 1'b0;
        chk("bp_seq3",   64'(oIC),    64'd3);
        chk("bp_vld3",   64'(oValid), 64'd1);
        cyc();
        chk("bp_empty",  64'(oValid), 64'd0);

        // Flush with skid full and a beat presented
        iReady = 1'b0; iValid = 1'b1;
        iIC = 32'd10; cyc();
        iIC = 32'd11; cyc();
        chk("fl_skidfull", 64'(oReady), 64'd0);
        iIC = 32'd12; flush = 1'b1; cyc();
        flush = 1'b0; iValid = 1'b0;
        chk("fl_ovalid", 64'(oValid), 64'd0);
        chk("fl_oready", 64'(oReady), 64'd1);
        iReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("fl_gone", 64'(oValid), 64'd0);
        end

        // Same-cycle write vs accept, then a write while held
        iReady = 1'b0; iIR = mk_ir(5'd0, 5'd1, 5'd2); iIC = 32'd20; iValid = 1'b1;
        rf_we = 1'b1; WAddr = 5'd1; WData = 32'd5; cyc();
        iValid = 1'b0; WAddr = 5'd2; WData = 32'd9; cyc();
        rf_we = 1'b0;
        chk("byp_vld", 64'(oValid), 64'd1);
        chk("byp_ic",  64'(oIC),    64'd20);
        chk("byp_op1", 64'(oOP1),   64'(exp_op1_byp));
        chk("byp_op2", 64'(oOP2),   64'(exp_op2_byp));
        iReady = 1'b1; cyc();
        chk("byp_drained", 64'(oValid), 64'd0);

        // Address 12 lies beyond NREGS=8: reads zero and does not alias onto r4
        rf_we = 1'b1; WAddr = 5'd12; WData = 32'd3; cyc();
        rf_we = 1'b0;
        iIR = mk_ir(5'd0, 5'd12, 5'd4); iValid = 1'b1; cyc();
        iValid = 1'b0;
        chk("nr_rs1",    64'(oRS1), 64'd12);
        chk("nr_op1",    64'(oOP1), 64'd0);
        chk("nr_alias4", 64'(oOP2), 64'd0);
        cyc();

        // Reset mid-operation discards a held beat
        iReady = 1'b0; iValid = 1'b1; iIC = 32'd30; cyc();
        iValid = 1'b0;
        chk("mr_held", 64'(oValid), 64'd1);
        reset = 1'b0; #2;
        chk("mr_ovalid", 64'(oValid), 64'd0);
        chk("mr_oic",    64'(oIC),    64'd0);
        reset = 1'b1;
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decode_stage_param.md
# decode_stage_param

Parametrised next-generation decode stage for the 3PA pipeline, sitting between fetch and execute. Decodes the 32-bit instruction word into register addresses, register-file operands and a sign-extended immediate, and carries IC/PPCCB/PC alongside. Replaces the single stall/flush register with a valid/ready handshake on both sides and a two-entry skid buffer. Width and register count are parameterised, and an optional writeback bypass keeps operands coherent.

## Interface
- DATA_W, 32, register/operand/immediate width (>= 23)
- PC_W, 32, program counter width
- IC_W, 32, instruction counter width
- NREGS, 32, implemented registers (2..32); reads of addresses >= NREGS return 0, writes to them are ignored

Ports:
- Clk  in  1  clock, all state updates on the rising edge
- reset  in  1  asynchronous, active-low reset
- rf_we  in  1  register-file write enable from writeback
- WAddr  in  5  write address
- WData  in  DATA_W  write data
- iIC  in  IC_W  instruction counter from fetch
- iPPCCB  in  1  predicted-branch bit from fetch
- iPC  in  PC_W  PC from fetch
- iIR  in  32  instruction word
- iValid  in  1  fetch beat valid
- oReady  out  1  decode can accept a beat
- iR2Select  in  1  0: rs2 = iIR[15:11]; 1: rs2 = iIR[26:22] (store source)
- iSignExtCtrl  in  2  EXT16/EXT17/EXT22/EXT23 codes from defines.vh
- flush  in  1  discard all held beats
- iReady  in  1  execute accepts the output beat
- oValid  out  1  output beat valid
- oIC, oPPCCB, oPC  out  IC_W/1/PC_W  forwarded fetch fields
- oRDS  out  5  iIR[26:22]
- oRS1  out  5  iIR[21:17]
- oRS2  out  5  per iR2Select
- oOP1, oOP2  out  DATA_W  register values of oRS1/oRS2
- oIM  out  DATA_W  sign-extended immediate

## Operation
- Register file: NREGS x DATA_W, written on rising Clk when rf_we=1 and WAddr < NREGS. It is read combinationally at accept time.
- Immediate: EXT16 sign-extends iIR[15:0]. EXT17 sign-extends [16:0]. EXT22 sign-extends [21:0]. EXT23 sign-extends [22:0]. All extend to DATA_W.
- Accept: a beat is accepted when iValid && oReady. The decoded beat (all o* fields) is captured into the output register, or into the skid register if the output register is occupied and not draining.
- Output register drain: on oValid && iReady. If the skid register is full, its beat moves to the output register in the same edge.
- oReady = !skid_full (registered).
- Flush: the output and skid registers are invalidated at the next edge. Any beat presented in the flush cycle is dropped. Flush has priority over accept and drain.
- Ordering is strictly preserved. A beat never bypasses an older one.

## Timing
- Reset asserted: oValid=0, oReady=1, all data outputs 0, skid empty, all registers 0. Mid-operation reset discards held beats immediately.
- Latency: accept at edge N gives oValid=1 after edge N with the decoded fields.
- Throughput: 1 beat/cycle while iReady=1.
- iReady low with output full and a beat accepted: the beat goes to skid and oReady=0 from the next cycle.
- Skid full, iReady high: output takes the skid beat and oReady=1 the next cycle. A new accept is not possible in that cycle.
- Both registers empty and iReady low: an accepted beat goes to output, not skid.
- Register write and read in the same cycle (macro off): the captured operand is the pre-write value.

## Configuration
- DECODE_BYPASS_EN defined:
  - At accept, if rf_we and WAddr equals rs1/rs2 (and < NREGS), the captured OP1/OP2 is WData.
  - Beats held in the output or skid register also update OP1/OP2 when a matching write occurs.
- DECODE_BYPASS_EN undefined: operands are captured once at accept with the pre-write value, and held beats are never refreshed.

## Test plan
- Reset, then write r1=1 and r2=2. Then present ADD r0,r1,r2 (iIC=7, iPPCCB=1, iPC=8) with iReady=1. Required next cycle: oValid=1, oRDS=0, oRS1=1, oOP1=1, oRS2=2, oOP2=2, oIC=7, oPC=8.
- Immediate modes: 16'h8000/EXT16 gives ffff8000. 23'h400000/EXT23 gives ffc00000. 22'h200000/EXT22 gives ffe00000. 17'h10000/EXT17 gives ffff0000. ST r2 with iR2Select=1 gives oRS2=2.
- Backpressure: hold iReady=0 and stream 3 beats IC=1,2,3. Beats 1 and 2 are held and oReady=0. Raise iReady: the output order is 1,2,3 with no loss or duplication.
- Flush with the skid full and iValid=1: next cycle oValid=0, oReady=1, and the flushed beats never appear.
- Bypass: accept ADD r0,r1,r2 in the cycle rf_we writes r1=5 and hold it with iReady=0. Then write r2=9. Macro on: oOP1=5 and oOP2=9. Macro off: oOP1=1 and oOP2=2.
- NREGS=8: write r12=3, then read r12. Required: oOP1=0.
